// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: cycle counts,
// engine state encoding and the radix-4 Booth recoding helper.
package multdiv_unit_pkg;

  // Edges from the start edge to the result strobe (one load cycle plus steps).
  localparam int MULT_CYCLES = 17;
  localparam int DIV_CYCLES  = 33;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } eng_state_t;

  // Radix-4 Booth addend for one recoding window {q[i+1], q[i], q[i-1]},
  // widened to 34 bits so that +/-2M never overflows the partial sum.
  function automatic logic [33:0] booth_addend(input logic [31:0] m,
                                               input logic [2:0]  bits);
    logic [33:0] m_ext;
    m_ext = {{2{m[31]}}, m};
    case (bits)
      3'b001, 3'b010: return m_ext;
      3'b011:         return m_ext << 1;
      3'b100:         return 34'd0 - (m_ext << 1);
      3'b101, 3'b110: return 34'd0 - m_ext;
      default:        return 34'd0;
    endcase
  endfunction

endpackage

// File: rtl/multdiv_unit_div_engine.sv
// Restoring divider on operand magnitudes with sign fix-up and
// divide-by-zero / overflow detection. Result held until the next start.
module multdiv_unit_div_engine
  import multdiv_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_exception,
  output logic        o_done
);

  eng_state_t       r_state;
  eng_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_rem;
  logic [31:0]      r_quo;
  logic [31:0]      r_div;
  logic             r_neg;
  logic             r_dz;
  logic [31:0]      r_result;
  logic             r_exc;

  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic [32:0]      w_rem_shift;
  logic [32:0]      w_trial;
  logic             w_fits;
  logic [31:0]      w_rem_step;
  logic [31:0]      w_quo_step;
  logic [31:0]      w_quo_signed;

  // Magnitudes; 0x80000000 maps onto itself, which reads correctly as 2^31.
  assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;

  // One restoring step: shift in the next dividend bit and try a subtract.
  assign w_rem_shift  = {r_rem, r_quo[31]};
  assign w_trial      = w_rem_shift - {1'b0, r_div};
  assign w_fits       = ~w_trial[32];
  assign w_rem_step   = w_fits ? w_trial[31:0] : w_rem_shift[31:0];
  assign w_quo_step   = {r_quo[30:0], w_fits};
  assign w_quo_signed = r_dz  ? 32'd0 :
                        r_neg ? (32'd0 - w_quo_step) : w_quo_step;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: abort beats start, start restarts from the load cycle.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = ST_IDLE;
    end else if (i_start) begin
      w_state_next = ST_BUSY;
    end else begin
      case (r_state)
        ST_BUSY: if (r_cnt == CNT_W'(DIV_CYCLES - 1)) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Datapath: capture on start, load magnitudes, iterate, publish on last step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_a      <= i_a;
      r_b      <= i_b;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (r_state == ST_BUSY && !i_abort) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == '0) begin
        r_rem <= '0;
        r_quo <= w_a_mag;
        r_div <= w_b_mag;
        r_neg <= r_a[31] ^ r_b[31];
        r_dz  <= (r_b == 32'd0);
      end else begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
        if (r_cnt == CNT_W'(DIV_CYCLES - 1)) begin
          r_result <= w_quo_signed;
          // A positive quotient of 2^31 only arises from 0x80000000 / -1.
          r_exc    <= r_dz | (~r_neg & w_quo_step[31]);
        end
      end
    end
  end

  assign o_result    = r_result;
  assign o_exception = r_exc;
  assign o_done      = (r_state == ST_DONE);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit. Radix-4 Booth multiplier
// inline, restoring divider in a sub-module, select flop picks the output.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  logic             w_mult_start;
  logic             w_div_start;
  logic             r_sel_mult;

  eng_state_t       r_mstate;
  eng_state_t       w_mstate_next;
  logic [CNT_W-1:0] r_mcnt;
  logic [31:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [64:0]      r_prod;
  logic [31:0]      r_mresult;
  logic             r_mexc;
  logic [33:0]      w_msum;
  logic [64:0]      w_prod_step;
  logic [31:0]      w_prod_hi;
  logic [31:0]      w_prod_lo;

  logic [31:0]      w_dresult;
  logic             w_dexc;
  logic             w_ddone;

  // Multiply wins when both pulses arrive together.
  assign w_mult_start = ctrl_MULT;
  assign w_div_start  = ctrl_DIV & ~ctrl_MULT;

  // Select flop: remembers which engine owns the shared outputs.
  always_ff @(posedge clock) begin
    if (reset)             r_sel_mult <= 1'b1;
    else if (w_mult_start) r_sel_mult <= 1'b1;
    else if (w_div_start)  r_sel_mult <= 1'b0;
  end

  // Multiplier state register.
  always_ff @(posedge clock) begin
    if (reset) r_mstate <= ST_IDLE;
    else       r_mstate <= w_mstate_next;
  end

  // Multiplier next state; a divide start aborts any multiply in flight.
  always_comb begin
    w_mstate_next = r_mstate;
    if (w_mult_start) begin
      w_mstate_next = ST_BUSY;
    end else if (w_div_start) begin
      w_mstate_next = ST_IDLE;
    end else begin
      case (r_mstate)
        ST_BUSY: if (r_mcnt == CNT_W'(MULT_CYCLES - 1)) w_mstate_next = ST_DONE;
        ST_DONE: w_mstate_next = ST_IDLE;
        default: w_mstate_next = r_mstate;
      endcase
    end
  end

  // Booth step: add the recoded multiple to the sign-extended high half,
  // then shift the {high, multiplier, q-1} register right by two.
  assign w_msum      = {{2{r_prod[64]}}, r_prod[64:33]} + booth_addend(r_mcand, r_prod[2:0]);
  assign w_prod_step = {w_msum, r_prod[32:2]};
  assign w_prod_hi   = w_prod_step[64:33];
  assign w_prod_lo   = w_prod_step[32:1];

  // Multiplier datapath: capture, load, 16 Booth steps, publish on the last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcnt    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_mresult <= '0;
      r_mexc    <= 1'b0;
    end else if (w_mult_start) begin
      r_mcnt    <= '0;
      r_mcand   <= data_operandA;
      r_mplier  <= data_operandB;
      r_mresult <= '0;
      r_mexc    <= 1'b0;
    end else if (r_mstate == ST_BUSY && !w_div_start) begin
      r_mcnt <= r_mcnt + CNT_W'(1);
      if (r_mcnt == '0) begin
        r_prod <= {32'd0, r_mplier, 1'b0};
      end else begin
        r_prod <= w_prod_step;
        if (r_mcnt == CNT_W'(MULT_CYCLES - 1)) begin
          r_mresult <= w_prod_lo;
          r_mexc    <= (w_prod_hi != {32{w_prod_lo[31]}});
        end
      end
    end
  end

  multdiv_unit_div_engine u_div (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_abort     (w_mult_start),
    .i_a         (data_operandA),
    .i_b         (data_operandB),
    .o_result    (w_dresult),
    .o_exception (w_dexc),
    .o_done      (w_ddone)
  );

  assign data_result    = r_sel_mult ? r_mresult : w_dresult;
  assign data_exception = r_sel_mult ? r_mexc    : w_dexc;
  assign data_resultRDY = r_sel_mult ? (r_mstate == ST_DONE) : w_ddone;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, hand-written
// multi-cycle corner sequences and randomized operations against a model.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mon_res [0:63];
  logic        mon_exc [0:63];
  int          mon_first;
  int          mon_count;

  typedef struct {
    logic        op;     // 0 = multiply, 1 = divide
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vecs [10];

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic void ref_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
    int     ia;
    int     ib;
    longint p;
    ia = a;
    ib = b;
    if (!op) begin
      p = longint'(ia) * longint'(ib);
      r = p[31:0];
      e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = ia / ib;
      e = 1'b0;
    end
  endfunction

  // Observe n edges; sampled 1 time unit after each rising edge.
  task automatic watch(input int n);
    mon_first = -1;
    mon_count = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      mon_res[k] = data_result;
      mon_exc[k] = data_exception;
      if (data_resultRDY) begin
        mon_count++;
        if (mon_first < 0) mon_first = k;
      end
    end
  endtask

  // Drive a start pulse; returns 1 time unit after the start edge E0,
  // with the operands already scrambled to prove they were captured.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input string name);
    int n;
    n = op ? 33 : 17;
    start_op(~op, op, a, b);
    watch(n + 1);
    check({name, "_busy_result"}, mon_res[1], 32'd0);
    check({name, "_rdy_edge"}, 32'(mon_first), 32'(n));
    check({name, "_rdy_count"}, 32'(mon_count), 32'd1);
    check({name, "_result"}, mon_res[n], exp_r);
    check({name, "_exception"}, 32'(mon_exc[n]), 32'(exp_e));
    check({name, "_hold"}, mon_res[n + 1], exp_r);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [5];
    logic [31:0] v;
    edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 40)) - 32'd20;
      2:       v = edge_vals[$urandom_range(0, 4)];
      default: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] er;
    logic        ee;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3"};
    vecs[1] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf"};
    vecs[2] = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, "mul_min_x1"};
    vecs[3] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1, "mul_min_sq"};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0, "mul_m1_m1"};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2"};
    vecs[6] = '{1'b1, 32'd100,        32'd7,         32'd14,        1'b0, "div_100_7"};
    vecs[7] = '{1'b1, 32'd5,          32'd0,         32'd0,         1'b1, "div_by_zero"};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
    vecs[9] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2"};

    // Reset state.
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    reset = 1'b0;

    // Idle with no control: nothing happens.
    watch(20);
    check("idle_rdy_count", 32'(mon_count), 32'd0);
    check("idle_result", mon_res[20], 32'd0);

    // Directed vector table.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].name);

    // Both control pulses together: multiply only.
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    watch(40);
    check("both_rdy_edge", 32'(mon_first), 32'd17);
    check("both_rdy_count", 32'(mon_count), 32'd1);
    check("both_result", mon_res[17], 32'd18);
    check("both_exception", 32'(mon_exc[17]), 32'd0);
    check("both_hold", mon_res[40], 32'd18);

    // Reset at E0+5 of a divide: abort, no strobe through E0+40.
    start_op(1'b0, 1'b1, 32'h0000_1234, 32'd7);
    watch(4);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_mid_result", data_result, 32'd0);
    check("rst_mid_exception", 32'(data_exception), 32'd0);
    check("rst_mid_rdy", 32'(data_resultRDY), 32'd0);
    watch(35);
    check("rst_mid_rdy_count", 32'(mon_count), 32'd0);
    check("rst_mid_result_late", mon_res[35], 32'd0);
    run_op(1'b0, 32'd2, 32'd2, 32'd4, 1'b0, "after_rst_mul");

    // Restart while busy: divide aborted by a multiply at E0+10.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    watch(9);
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    watch(30);
    check("abort_rdy_edge", 32'(mon_first), 32'd17);
    check("abort_rdy_count", 32'(mon_count), 32'd1);
    check("abort_result", mon_res[17], 32'd15);
    check("abort_hold", mon_res[30], 32'd15);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = pick_operand();
      b  = pick_operand();
      ref_model(op, a, b, er, ee);
      run_op(op, a, b, er, ee, $sformatf("rnd%0d_%s", i, op ? "div" : "mul"));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
